data_mem: RTL and testbench
===========================

DATA_MEM -- requirements
Module: data_mem

Interface
REQ-001 Parameter DEPTH, default 256, SHALL set the number of 32-bit storage words (power of 2, at least 4).
REQ-002 Parameter LATENCY, default 2, SHALL set the number of ACCESS-state cycles per request (at least 1).
REQ-003 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-004 Port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 Port address, input, 32 bits: byte address, driven by the CPU MA-stage ALU result.
REQ-006 Port write_data, input, 32 bits: store data from the CPU MA stage.
REQ-007 Port mem_read, input, 2 bits: load size code (00 none, 01 byte, 10 half, 11 word).
REQ-008 Port mem_write, input, 2 bits: store size code, using the same encoding as mem_read.
REQ-009 Port load_unsigned, input, 1 bit: 1 zero-extends byte/half loads; 0 sign-extends them.
REQ-010 Port read_data, output, 32 bits: registered load result, returned to the CPU as dmem_data_out.
REQ-011 Port busy_wait, output, 1 bit: stall request to the CPU pipeline.
REQ-012 Port access_err, output, 1 bit: single-cycle error pulse.

Function
REQ-013 FSM states SHALL be IDLE, ACCESS and DONE.
REQ-014 In IDLE, a nonzero mem_read or mem_write SHALL capture address, data, size and sign into holding registers at the edge, clear the latency counter, and move the FSM to ACCESS.
REQ-015 busy_wait SHALL be combinational: high in IDLE when a request is present, high throughout ACCESS, and low in DONE.
REQ-016 busy_wait therefore SHALL be high for exactly LATENCY+1 consecutive cycles per request.
REQ-017 In ACCESS, the counter SHALL increment each cycle; on the edge ending cycle LATENCY the access SHALL execute and the FSM SHALL move to DONE.
REQ-018 A store SHALL update only the addressed byte lanes, little-endian: byte lane = address[1:0]; half lane = address[1].
REQ-019 A load SHALL register the lane-selected value into read_data, extended per load_unsigned, at the same edge that enters DONE.
REQ-020 read_data SHALL hold its value until the next load completes; stores SHALL NOT change it.
REQ-021 DONE SHALL last exactly one cycle, SHALL ignore its inputs, and SHALL return to IDLE, so a held request is never re-issued.
REQ-022 The word index SHALL be address[log2(DEPTH)+1:2]; higher address bits SHALL be ignored (the address space wraps).
REQ-023 A misaligned access (half with address[0]=1, or word with address[1:0]≠00) SHALL still take the full latency, SHALL NOT modify storage, SHALL leave read_data unchanged, and SHALL pulse access_err in the DONE cycle.
REQ-024 mem_read and mem_write both nonzero SHALL be treated as a store only, with access_err pulsed in the DONE cycle.
REQ-025 Input changes during ACCESS SHALL have no effect; only the captured request SHALL execute.

Reset
REQ-026 Asserting reset SHALL immediately force: state IDLE, counter 0, read_data 0, access_err 0, holding registers 0.
REQ-027 Reset asserted during ACCESS SHALL abort the request, and the pending store SHALL NOT be committed.
REQ-028 Storage array contents SHALL NOT be reset.

Structure
REQ-029 Package dmem_pkg SHALL hold the size-code constants (SZ_NONE, SZ_BYTE, SZ_HALF, SZ_WORD) and the FSM state typedef.
REQ-030 Sub-module dmem_align SHALL be combinational and provide store lane/byte-enable generation, load lane extraction with extension, and misalignment detection.

Verification
REQ-031 Word store 0xDEADBEEF to address 0x10, then word load from 0x10 -> busy_wait high for 3 cycles each; read_data = 0xDEADBEEF in the DONE cycle.
REQ-032 Byte load from 0x13 with load_unsigned=0, then with 1 -> 0xFFFFFFDE, then 0x000000DE.
REQ-033 Half store 0x1234 to 0x12, then word load from 0x10 -> 0x1234BEEF.
REQ-034 Word load from 0x11 -> access_err pulses once in the DONE cycle; read_data is unchanged; storage is unchanged.
REQ-035 Word store 0xAAAAAAAA to 0x20 with reset pulsed low in the second ACCESS cycle -> busy_wait low immediately; a later word load from 0x20 does not return 0xAAAAAAAA.
REQ-036 Word store to 0x410 with DEPTH=256, then word load from 0x010 -> returns the stored value (address wrap).

Source files
------------

// File: rtl/dmem_pkg.sv
// dmem_pkg: size codes and FSM state type shared by data_mem and dmem_align
package dmem_pkg;
    localparam logic [1:0] SZ_NONE = 2'b00;
    localparam logic [1:0] SZ_BYTE = 2'b01;
    localparam logic [1:0] SZ_HALF = 2'b10;
    localparam logic [1:0] SZ_WORD = 2'b11;
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
endpackage

// File: rtl/dmem_align.sv
// dmem_align: little-endian lane steering, load extension and misalignment detection
// Ports: addr_lo/size/load_unsigned describe the access; wdata -> byte_en/wlane for stores;
//        rword -> rdata for loads; misaligned flags half/word accesses off their boundary.
module dmem_align import dmem_pkg::*; (
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic        load_unsigned,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  byte_en,
    output logic [31:0] wlane,
    output logic [31:0] rdata,
    output logic        misaligned
);
    logic [7:0]  b;
    logic [15:0] h;
    always_comb begin
        b = 8'(rword >> {addr_lo, 3'b000});
        h = addr_lo[1] ? rword[31:16] : rword[15:0];
        byte_en = size == SZ_BYTE ? 4'b0001 << addr_lo :
                  size == SZ_HALF ? (addr_lo[1] ? 4'b1100 : 4'b0011) :
                  size == SZ_WORD ? 4'b1111 : 4'b0000;
        // replicate the store data so every enabled lane sees the right bits
        wlane = size == SZ_BYTE ? {4{wdata[7:0]}} :
                size == SZ_HALF ? {2{wdata[15:0]}} : wdata;
        rdata = size == SZ_BYTE ? {{24{~load_unsigned & b[7]}}, b} :
                size == SZ_HALF ? {{16{~load_unsigned & h[15]}}, h} : rword;
        misaligned = (size == SZ_HALF && addr_lo[0]) || (size == SZ_WORD && addr_lo != 2'b00);
    end
endmodule

// File: rtl/data_mem.sv
// data_mem: multi-cycle 32-bit data memory with byte/half/word access and CPU stall
// Ports: clk, reset (async, active-low); address/write_data/mem_read/mem_write/load_unsigned
//        from the CPU MA stage; read_data (registered load result), busy_wait (combinational
//        stall), access_err (one-cycle pulse in DONE on misaligned or read+write requests).
module data_mem import dmem_pkg::*; #(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    input  logic [1:0]  mem_read,
    input  logic [1:0]  mem_write,
    input  logic        load_unsigned,
    output logic [31:0] read_data,
    output logic        busy_wait,
    output logic        access_err
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(LATENCY + 1);
    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [AW+1:0]   addr_q, addr_d;
    logic [31:0]     wdata_q, wdata_d;
    logic [1:0]      size_q, size_d;
    logic            uns_q, uns_d;
    logic            wr_q, wr_d;
    logic            both_q, both_d;
    logic [31:0]     read_data_q, read_data_d;
    logic            access_err_q, access_err_d;
    logic [31:0]     mem [DEPTH];
    logic [3:0]      byte_en;
    logic [31:0]     wlane, rdata;
    logic            misaligned, req, last, commit;
    logic            addr_unused;
    // upper address bits are ignored so the address space wraps
    assign addr_unused = ^address[31:AW+2];
    dmem_align u_align (
        .addr_lo       (addr_q[1:0]),
        .size          (size_q),
        .load_unsigned (uns_q),
        .wdata         (wdata_q),
        .rword         (mem[addr_q[AW+1:2]]),
        .byte_en       (byte_en),
        .wlane         (wlane),
        .rdata         (rdata),
        .misaligned    (misaligned)
    );
    assign req        = (|mem_read) || (|mem_write);
    assign last       = state_q == ACCESS && cnt_q == CW'(LATENCY - 1);
    assign commit     = last && wr_q && !misaligned && reset;
    assign busy_wait  = reset && ((state_q == IDLE && req) || state_q == ACCESS);
    assign read_data  = read_data_q;
    assign access_err = access_err_q;
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        size_d       = size_q;
        uns_d        = uns_q;
        wr_d         = wr_q;
        both_d       = both_q;
        read_data_d  = read_data_q;
        access_err_d = 1'b0;
        if (state_q == IDLE && req) begin
            state_d = ACCESS;
            cnt_d   = '0;
            addr_d  = address[AW+1:0];
            wdata_d = write_data;
            // a simultaneous read+write executes as the store alone
            size_d  = |mem_write ? mem_write : mem_read;
            uns_d   = load_unsigned;
            wr_d    = |mem_write;
            both_d  = (|mem_read) && (|mem_write);
        end else if (state_q == ACCESS) begin
            cnt_d = cnt_q + CW'(1);
            if (last) begin
                state_d      = DONE;
                access_err_d = misaligned || both_q;
                read_data_d  = !wr_q && !misaligned ? rdata : read_data_q;
            end
        end else if (state_q == DONE) begin
            state_d = IDLE;
        end
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            size_q       <= SZ_NONE;
            uns_q        <= 1'b0;
            wr_q         <= 1'b0;
            both_q       <= 1'b0;
            read_data_q  <= '0;
            access_err_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            size_q       <= size_d;
            uns_q        <= uns_d;
            wr_q         <= wr_d;
            both_q       <= both_d;
            read_data_q  <= read_data_d;
            access_err_q <= access_err_d;
        end
    end
    // storage is deliberately not reset
    always_ff @(posedge clk) begin
        if (commit)
            for (int i = 0; i < 4; i++)
                if (byte_en[i]) mem[addr_q[AW+1:2]][8*i +: 8] <= wlane[8*i +: 8];
    end
endmodule

// File: tb/tb_data_mem.sv
// tb_data_mem: directed self-checking bench for data_mem (DEPTH=256, LATENCY=2)
module tb_data_mem;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] address = '0;
    logic [31:0] write_data = '0;
    logic [1:0]  mem_read = 2'b00;
    logic [1:0]  mem_write = 2'b00;
    logic        load_unsigned = 1'b0;
    logic [31:0] read_data;
    logic        busy_wait;
    logic        access_err;
    int          n_pass = 0;
    int          n_chk = 0;
    localparam logic [1:0] N = 2'b00, B = 2'b01, H = 2'b10, W = 2'b11;
    data_mem #(.DEPTH(256), .LATENCY(2)) dut (
        .clk           (clk),
        .reset         (reset),
        .address       (address),
        .write_data    (write_data),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .load_unsigned (load_unsigned),
        .read_data     (read_data),
        .busy_wait     (busy_wait),
        .access_err    (access_err)
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask
    task automatic op(input string tag, input logic [1:0] rd, input logic [1:0] wr, input logic uns,
                      input logic [31:0] a, input logic [31:0] d, input logic scr,
                      input logic exp_err, input logic [31:0] exp_rd);
        int n = 0;
        int errs = 0;
        logic err_done;
        logic [31:0] rd_done;
        @(negedge clk);
        mem_read = rd; mem_write = wr; load_unsigned = uns; address = a; write_data = d;
        #1;
        while (busy_wait && n < 20) begin
            n++;
            if (access_err) errs++;
            if (scr && n == 2) begin
                mem_read = W; mem_write = W; address = 32'h20; write_data = 32'h0BAD_0BAD;
            end
            @(negedge clk);
            #1;
        end
        rd_done = read_data;
        err_done = access_err;
        if (access_err) errs++;
        mem_read = N; mem_write = N; load_unsigned = 1'b0;
        @(negedge clk);
        #1;
        if (access_err) errs++;
        check({tag, " busy"}, 32'(n), 32'd3);
        check({tag, " rdata"}, rd_done, exp_rd);
        check({tag, " err_done"}, {31'd0, err_done}, {31'd0, exp_err});
        check({tag, " err_pulses"}, 32'(errs), {31'd0, exp_err});
    endtask
    initial begin
        #2;
        check("rst read_data", read_data, 32'h0);
        check("rst access_err", {31'd0, access_err}, 32'd0);
        check("rst busy", {31'd0, busy_wait}, 32'd0);
        mem_read = W;
        #1;
        check("rst busy gated", {31'd0, busy_wait}, 32'd0);
        mem_read = N;
        @(negedge clk);
        #2 reset = 1'b1;
        op("st_w10",     N, W, 0, 32'h10,  32'hDEADBEEF, 0, 0, 32'h0000_0000);
        op("ld_w10",     W, N, 0, 32'h10,  32'h0,        0, 0, 32'hDEAD_BEEF);
        op("ld_b13_s",   B, N, 0, 32'h13,  32'h0,        0, 0, 32'hFFFF_FFDE);
        op("ld_b13_u",   B, N, 1, 32'h13,  32'h0,        0, 0, 32'h0000_00DE);
        op("st_h12",     N, H, 0, 32'h12,  32'h0000_1234, 0, 0, 32'h0000_00DE);
        op("ld_w10_b",   W, N, 0, 32'h10,  32'h0,        0, 0, 32'h1234_BEEF);
        op("ld_h10_s",   H, N, 0, 32'h10,  32'h0,        0, 0, 32'hFFFF_BEEF);
        op("ld_h12_u",   H, N, 1, 32'h12,  32'h0,        0, 0, 32'h0000_1234);
        op("ld_w11_mis", W, N, 0, 32'h11,  32'h0,        0, 1, 32'h0000_1234);
        op("st_w12_mis", N, W, 0, 32'h12,  32'hFFFF_FFFF, 0, 1, 32'h0000_1234);
        op("ld_h11_mis", H, N, 0, 32'h11,  32'h0,        0, 1, 32'h0000_1234);
        op("ld_w10_c",   W, N, 0, 32'h10,  32'h0,        0, 0, 32'h1234_BEEF);
        op("rw_both",    W, B, 0, 32'h10,  32'h0000_0077, 0, 1, 32'h1234_BEEF);
        op("ld_w10_d",   W, N, 0, 32'h10,  32'h0,        0, 0, 32'h1234_BE77);
        op("st_w410",    N, W, 0, 32'h410, 32'hCAFE_F00D, 0, 0, 32'h1234_BE77);
        op("ld_w10_scr", W, N, 0, 32'h10,  32'h0,        1, 0, 32'hCAFE_F00D);
        op("st_w20",     N, W, 0, 32'h20,  32'h5555_5555, 0, 0, 32'hCAFE_F00D);
        op("st_b21",     N, B, 0, 32'h21,  32'h0000_00A5, 0, 0, 32'hCAFE_F00D);
        op("ld_b21_s",   B, N, 0, 32'h21,  32'h0,        0, 0, 32'hFFFF_FFA5);
        @(negedge clk);
        mem_write = W; address = 32'h20; write_data = 32'hAAAA_AAAA;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("abort busy", {31'd0, busy_wait}, 32'd0);
        check("abort read_data", read_data, 32'h0);
        check("abort access_err", {31'd0, access_err}, 32'd0);
        mem_write = N;
        #2 reset = 1'b1;
        op("ld_w20_post", W, N, 0, 32'h20, 32'h0, 0, 0, 32'h5555_A555);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
